if_id_skid_pipe: RTL

//  Parametrised IF/ID pipeline stage for the RV32I core, replacing the fixed
//  32-bit PC/instruction latch. Carries {pc, instr} from fetch to decode with a

---
 rtl/if_id_skid_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_id_skid_pipe.sv
// IF/ID stage: carries {pc, instr} from fetch to decode through a 2-entry skid buffer, flush inserts a NOP bubble.
// Latency 1 cycle from accept to out_*; in_ready is registered and drops only when both entries are held.
// Backpressure: a stalled out_ready holds the head stable while the skid entry absorbs the word already in flight.
module if_id_skid_pipe #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [1:0]      occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_out_valid;
    logic            r_in_ready;
    logic [1:0]      r_occ;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_instr;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_main_pc_nxt;
    logic [XLEN-1:0] w_main_instr_nxt;
    logic [XLEN-1:0] w_skid_pc_nxt;
    logic [XLEN-1:0] w_skid_instr_nxt;
    logic            w_acc_in;
    logic            w_acc_out;

    assign w_acc_in  = in_valid & r_in_ready;
    assign w_acc_out = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_pc_nxt    = r_main_pc;
        w_main_instr_nxt = r_main_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_main_pc_nxt    = RESET_PC;
            w_main_instr_nxt = NOP_INSTR;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc_in) begin
                        w_state_nxt      = ST_ONE;
                        w_main_pc_nxt    = in_pc;
                        w_main_instr_nxt = in_instr;
                    end
                end
                ST_ONE: begin
                    if (w_acc_in && w_acc_out) begin
                        w_main_pc_nxt    = in_pc;
                        w_main_instr_nxt = in_instr;
                    end else if (w_acc_in) begin
                        w_state_nxt      = ST_FULL;
                        w_skid_pc_nxt    = in_pc;
                        w_skid_instr_nxt = in_instr;
                    end else if (w_acc_out) begin
                        // pc of the drained entry stays visible; only instr becomes the bubble
                        w_state_nxt      = ST_EMPTY;
                        w_main_instr_nxt = NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (w_acc_out) begin
                        w_state_nxt      = ST_ONE;
                        w_main_pc_nxt    = r_skid_pc;
                        w_main_instr_nxt = r_skid_instr;
                    end
                end
                default: begin
                    w_state_nxt      = ST_EMPTY;
                    w_main_pc_nxt    = RESET_PC;
                    w_main_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_occ        <= 2'd0;
            r_main_pc    <= RESET_PC;
            r_main_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_valid  <= (w_state_nxt != ST_EMPTY);
            r_in_ready   <= (w_state_nxt != ST_FULL);
            r_occ        <= (w_state_nxt == ST_FULL) ? 2'd2 :
                            (w_state_nxt == ST_ONE)  ? 2'd1 : 2'd0;
            r_main_pc    <= w_main_pc_nxt;
            r_main_instr <= w_main_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign out_instr = r_main_instr;
    assign occupancy = r_occ;

endmodule
